// File: rtl/fifo_pkg.sv
// fifo_pkg: default sizing constants shared by the FIFO top and its storage
package fifo_pkg;
    localparam int DATA_SIZE    = 8;
    localparam int ADDRESS_SIZE = 3;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register-array storage with one synchronous write and one asynchronous read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int data_Size    = DATA_SIZE,
    parameter int address_Size = ADDRESS_SIZE
) (
    input  logic                    Clk,
    input  logic                    w_en,
    input  logic [address_Size-1:0] w_addr,
    input  logic [data_Size-1:0]    w_data,
    input  logic [address_Size-1:0] r_addr,
    output logic [data_Size-1:0]    r_data
);
    logic [data_Size-1:0] mem_q [2**address_Size];

    // storage is deliberately not reset; the pointers alone decide what is valid
    always_ff @(posedge Clk) begin
        if (w_en) mem_q[w_addr] <= w_data;
    end

    // asynchronous read gives first-word-fall-through at the top level
    always_comb r_data = mem_q[r_addr];
endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock FWFT FIFO with wrap-bit pointers and an asynchronous reset
module async_fifo
    import fifo_pkg::*;
#(
    parameter int data_Size    = DATA_SIZE,
    parameter int address_Size = ADDRESS_SIZE
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [data_Size-1:0] write_Data,
    input  logic                 w_Inc,
    input  logic                 r_Inc,
    output logic [data_Size-1:0] read_Data,
    output logic                 fifo_Full,
    output logic                 fifo_Empty
);
    localparam int AW = address_Size;
    typedef logic [AW:0] ptr_t;

    ptr_t                 wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 wr_en, rd_en;
    logic [data_Size-1:0] mem_data;

    // flags come only from registered pointers; requests are gated by those flags
    always_comb begin
        fifo_Empty = (wptr_q == rptr_q);
        fifo_Full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        wr_en      = w_Inc && !fifo_Full;
        rd_en      = r_Inc && !fifo_Empty;
        wptr_d     = wptr_q + ptr_t'(wr_en);
        rptr_d     = rptr_q + ptr_t'(rd_en);
        read_Data  = fifo_Empty ? '0 : mem_data;
    end

    // pointer registers; reset empties the queue immediately without touching storage
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_mem #(
        .data_Size   (data_Size),
        .address_Size(address_Size)
    ) u_mem (
        .Clk   (Clk),
        .w_en  (wr_en),
        .w_addr(wptr_q[AW-1:0]),
        .w_data(write_Data),
        .r_addr(rptr_q[AW-1:0]),
        .r_data(mem_data)
    );
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed self-checking bench for async_fifo
module tb_async_fifo;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] write_Data = '0;
    logic       w_Inc = 1'b0;
    logic       r_Inc = 1'b0;
    logic [7:0] read_Data;
    logic       fifo_Full, fifo_Empty;
    int         n_chk = 0;
    int         n_pass = 0;

    async_fifo dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .write_Data(write_Data),
        .w_Inc     (w_Inc),
        .r_Inc     (r_Inc),
        .read_Data (read_Data),
        .fifo_Full (fifo_Full),
        .fifo_Empty(fifo_Empty)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        w_Inc = w;
        r_Inc = r;
        write_Data = d;
        @(posedge Clk);
        #1;
        w_Inc = 1'b0;
        r_Inc = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, read_Data, exp);
        cyc(1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        #1;
        chk("rst_empty", fifo_Empty, 1);
        chk("rst_full", fifo_Full, 0);
        chk("rst_data", read_Data, 0);
        @(negedge Clk);
        Rst = 1'b0;

        cyc(1'b1, 1'b0, 8'd0);
        chk("first_write_not_empty", fifo_Empty, 0);
        for (int i = 1; i < 8; i++) begin
            chk("fill_not_full", fifo_Full, 0);
            cyc(1'b1, 1'b0, 8'(i));
        end
        chk("fill_full", fifo_Full, 1);
        cyc(1'b1, 1'b0, 8'd8);
        chk("overwrite_full", fifo_Full, 1);
        chk("overwrite_head", read_Data, 0);

        for (int i = 0; i < 8; i++) pop_chk("drain", 8'(i));
        chk("drain_empty", fifo_Empty, 1);
        chk("drain_data0", read_Data, 0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("underflow_empty", fifo_Empty, 1);
        cyc(1'b1, 1'b0, 8'h33);
        chk("after_underflow_head", read_Data, 8'h33);
        pop_chk("after_underflow_pop", 8'h33);
        chk("after_underflow_empty", fifo_Empty, 1);

        begin
            int wi = 0;
            int ri = 0;
            for (int c = 0; c < 200 && ri < 15; c++) begin
                logic w, r;
                w = (wi < 15) && !fifo_Full;
                r = !fifo_Empty && (c % 3 == 2);
                if (r) begin
                    chk("wrap_order", read_Data, 8'(ri));
                    ri++;
                end
                if (w) wi++;
                cyc(w, r, 8'(wi - (w ? 1 : 0)));
            end
            chk("wrap_count", ri, 15);
            chk("wrap_empty", fifo_Empty, 1);
        end

        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i));
        cyc(1'b1, 1'b1, 8'h14);
        for (int i = 1; i < 5; i++) pop_chk("simul_mid", 8'h10 + 8'(i));
        chk("simul_mid_empty", fifo_Empty, 1);

        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i));
        chk("simul_full_pre", fifo_Full, 1);
        cyc(1'b1, 1'b1, 8'hEE);
        chk("simul_full_post", fifo_Full, 0);
        for (int i = 1; i < 8; i++) pop_chk("simul_full", 8'h20 + 8'(i));
        chk("simul_full_empty", fifo_Empty, 1);

        cyc(1'b1, 1'b1, 8'h55);
        chk("simul_empty_post", fifo_Empty, 0);
        pop_chk("simul_empty_data", 8'h55);
        chk("simul_empty_after", fifo_Empty, 1);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i));
        chk("pre_reset_head", read_Data, 8'h60);
        Rst = 1'b1;
        #1;
        chk("midrst_empty", fifo_Empty, 1);
        chk("midrst_full", fifo_Full, 0);
        chk("midrst_data", read_Data, 0);
        Rst = 1'b0;
        cyc(1'b1, 1'b0, 8'hA5);
        pop_chk("midrst_first", 8'hA5);
        chk("midrst_final_empty", fifo_Empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 The block SHALL have one clock; its reset SHALL be asynchronous and active-high.
REQ-002 Parameter data_Size, default 8, SHALL set the width of one stored word in bits.
REQ-003 Parameter address_Size, default 3, SHALL set the address width, giving a depth of 2**address_Size words (8 by default).
REQ-004 Port Clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port Rst, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-006 Port write_Data, input, data_Size bits, SHALL carry the word to be written.
REQ-007 Port w_Inc, input, 1 bit, SHALL be the write request.
REQ-008 Port r_Inc, input, 1 bit, SHALL be the read request (pop).
REQ-009 Port read_Data, output, data_Size bits, SHALL carry the head-of-queue word.
REQ-010 Port fifo_Full, output, 1 bit, SHALL be high when all 2**address_Size entries are occupied.
REQ-011 Port fifo_Empty, output, 1 bit, SHALL be high when no entries are occupied.

Function
REQ-012 Write pointer and read pointer SHALL each be address_Size+1 bits wide, binary, with the low address_Size bits addressing memory and the MSB acting as the wrap bit.
REQ-013 A write SHALL occur on a rising Clk edge when w_Inc=1 and fifo_Full=0; write_Data is stored at the write address and the write pointer increments by 1 modulo 2**(address_Size+1).
REQ-014 A write request while fifo_Full=1 SHALL be ignored, with no change to memory or pointers.
REQ-015 A read SHALL occur on a rising Clk edge when r_Inc=1 and fifo_Empty=0; the read pointer increments by 1 modulo 2**(address_Size+1).
REQ-016 A read request while fifo_Empty=1 SHALL be ignored.
REQ-017 read_Data SHALL be first-word-fall-through: combinationally equal to the memory word at the read address whenever fifo_Empty=0, and 0 whenever fifo_Empty=1.
REQ-018 The word written by a write SHALL be visible on read_Data in the cycle after that write edge if it is the head of the queue (zero-cycle read latency).
REQ-019 fifo_Empty SHALL be 1 exactly when the write and read pointers are equal across all address_Size+1 bits.
REQ-020 fifo_Full SHALL be 1 exactly when the pointer MSBs differ and the low address_Size bits are equal.
REQ-021 fifo_Full and fifo_Empty SHALL be decoded from registered pointers only, glitch-free and with no combinational path from w_Inc or r_Inc.
REQ-022 A simultaneous write and read, when neither is blocked, SHALL both take effect, leaving occupancy unchanged.
REQ-023 A simultaneous write and read while full SHALL perform only the read; the FIFO is then not full.
REQ-024 A simultaneous write and read while empty SHALL perform only the write; the FIFO is then not empty.
REQ-025 Pointer wrap-around SHALL preserve strict FIFO order indefinitely.

Reset
REQ-026 While Rst=1, regardless of Clk, both pointers SHALL be 0, fifo_Empty=1, fifo_Full=0 and read_Data=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries immediately; memory contents SHALL NOT be reset.
REQ-028 The first write SHALL be accepted on the first rising Clk edge after Rst deasserts.

Structure
REQ-029 Package fifo_pkg SHALL hold the default constants DATA_SIZE=8 and ADDRESS_SIZE=3.
REQ-030 Storage SHALL be a sub-module fifo_mem, a 2**address_Size by data_Size register array.
- fifo_mem has one synchronous write port and one asynchronous read port.
- Pointer and flag logic SHALL reside in the top module.

Verification
REQ-031 Reset check: assert Rst with no clock edges -> fifo_Empty=1, fifo_Full=0, read_Data=0.
REQ-032 Fill check: write 0..7 with r_Inc=0 -> fifo_Full=1 after the 8th write edge; a 9th write of 8 is ignored, and subsequent reads return 0..7 only.
REQ-033 Drain check: read a full FIFO 8 times -> read_Data shows 0,1,...,7 in order; fifo_Empty=1 after the 8th read; a 9th read leaves pointers unchanged.
REQ-034 Wrap and order check: 15 writes of 0..14 gated by fifo_Full, interleaved with reads -> read sequence is exactly 0..14 with no loss or duplication.
REQ-035 Simultaneous-access check: both requests at occupancy 4 -> occupancy stays 4; both requests while full -> occupancy becomes 7 and write_Data is dropped; both requests while empty -> occupancy becomes 1.
REQ-036 Mid-operation reset check: with 5 entries stored, pulse Rst between edges -> fifo_Empty=1 immediately; the next write of 0xA5 is read back first.
